// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl shared types and defaults.
// Widths, reset pc, credit depth, FSM state and queue entry.
package fetch_ctrl_pkg;

    localparam int ADDR = 32;
    localparam int DATA = 32;
    localparam logic [ADDR-1:0] RESET_PC_DEF = '0;
    localparam int DEPTH_DEF = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR-1:0] pc;
        logic [DATA-1:0] inst;
    } fetch_word_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory read port between fetch_ctrl and imem.
// master = fetch side, slave = memory side.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
();

    logic            imem_req_o;
    logic [ADDR-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [DATA-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/fetch_q.sv
// Small synchronous FIFO, used for returned words
// and for the pcs of reads still in flight.
module fetch_q #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & (~full_o | pop_i) & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    // Pointers and count; storage zeroed so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the pc, issues imem word reads,
// drops stale returns after redirects, buffers words for decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    input  logic            flush_i,
    input  logic [ADDR-1:0] faddr_i,
    fetch_ctrl_if.master    imem,
    output logic [ADDR-1:0] pc_o,
    output logic [DATA-1:0] inst_o,
    output logic            v_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = DEPTH[CW:0];

    state_e          state_q;
    logic [ADDR-1:0] pc_q;
    logic [ADDR-1:0] pc_d;
    logic [CW-1:0]   kill_q;
    logic [CW-1:0]   kill_d;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   qcnt;
    logic [ADDR-1:0] inflight_pc;
    fetch_word_t     head;
    fetch_word_t     rx_word;
    logic            redirect;
    logic            credit_ok;
    logic            fire;
    logic            live_rv;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            q_full;
    logic            t_empty;
    logic            t_full;

    assign redirect  = flush_i | branch_i;
    assign credit_ok = ({1'b0, outst} + {1'b0, qcnt}) < CREDITS;

    assign imem.imem_req_o  = (state_q == S_RUN) & v_i
                            & ~redirect & credit_ok;
    assign imem.imem_addr_o = pc_q;

    assign fire    = imem.imem_req_o & imem.imem_gnt_i;
    assign live_rv = imem.imem_rvalid_i & (kill_q == '0);
    assign q_push  = live_rv & ~redirect;
    assign q_pop   = v_o & ~stall_i;
    assign rx_word = '{pc: inflight_pc, inst: imem.imem_rdata_i};

    assign v_o    = ~q_empty;
    assign pc_o   = head.pc;
    assign inst_o = head.inst;

    fetch_q #(
        .W     (ADDR),
        .DEPTH (DEPTH)
    ) u_track (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fire),
        .pop_i   (imem.imem_rvalid_i),
        .clr_i   (1'b0),
        .din_i   (pc_q),
        .dout_o  (inflight_pc),
        .full_o  (t_full),
        .empty_o (t_empty),
        .count_o (outst)
    );

    fetch_q #(
        .W     ($bits(fetch_word_t)),
        .DEPTH (DEPTH)
    ) u_q (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clr_i   (redirect),
        .din_i   (rx_word),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (qcnt)
    );

    // Next pc: flush beats branch, both beat sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = faddr_i;
        end else if (branch_i) begin
            pc_d = baddr_i;
        end else if (fire) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // On redirect every read still in flight afterwards is stale.
    always_comb begin
        kill_d = kill_q;
        if (redirect) begin
            kill_d = outst - {{(CW-1){1'b0}}, imem.imem_rvalid_i};
        end else if (imem.imem_rvalid_i && kill_q != '0) begin
            kill_d = kill_q - 1'b1;
        end
    end

    // Run/idle FSM together with pc and kill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            kill_q <= kill_d;
            unique case (state_q)
                S_IDLE: if (v_i) state_q <= S_RUN;
                S_RUN:  if (!v_i) state_q <= S_IDLE;
            endcase
        end
    end

    a_rv_orphan: assert property (@(posedge clk) disable iff (!rst)
        !(imem.imem_rvalid_i && t_empty));
    a_gnt_noreq: assert property (@(posedge clk) disable iff (!rst)
        !(imem.imem_gnt_i && !imem.imem_req_o));
    a_q_ovf: assert property (@(posedge clk) disable iff (!rst)
        !(q_push && q_full && !q_pop));
    a_t_ovf: assert property (@(posedge clk) disable iff (!rst)
        !(fire && t_full && !imem.imem_rvalid_i));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: imem responder, pc reference scoreboard,
// directed reset/stall/redirect cases and a random soak.
module tb_fetch_ctrl
    import fetch_ctrl_pkg::*;
;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            v_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            branch_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [ADDR-1:0] baddr_i = '0;
    logic [ADDR-1:0] faddr_i = '0;
    logic [ADDR-1:0] pc_o;
    logic [DATA-1:0] inst_o;
    logic            v_o;

    fetch_ctrl_if bus();

    fetch_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .v_i      (v_i),
        .stall_i  (stall_i),
        .branch_i (branch_i),
        .baddr_i  (baddr_i),
        .flush_i  (flush_i),
        .faddr_i  (faddr_i),
        .imem     (bus),
        .pc_o     (pc_o),
        .inst_o   (inst_o),
        .v_o      (v_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Cycle index, constant between posedges.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA-1:0] memf(input logic [ADDR-1:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- imem responder ----------------
    typedef struct {
        logic [ADDR-1:0] a;
        int              due;
    } rd_t;

    rd_t pend[$];
    int  gnt_pct = 100;
    int  dly_min = 0;
    int  dly_max = 0;
    int  gnt_cnt = 0;
    int  out_tb = 0;

    // Decide gnt/rvalid for the coming edge, in-order returns.
    initial begin
        logic g;
        logic rv;
        int   d;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            g  = 1'b0;
            rv = 1'b0;
            if (rst) begin
                g = bus.imem_req_o && ($urandom_range(99) < gnt_pct);
                if (g) begin
                    d = dly_min + int'($urandom_range(dly_max - dly_min));
                    pend.push_back('{bus.imem_addr_o, cyc + 1 + d});
                    gnt_cnt++;
                end
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    rv = 1'b1;
                    bus.imem_rdata_i = memf(pend[0].a);
                    void'(pend.pop_front());
                end
            end
            bus.imem_gnt_i    = g;
            bus.imem_rvalid_i = rv;
            out_tb = out_tb + int'(g) - int'(rv);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int              c;
        logic [ADDR-1:0] tgt;
    } redir_t;

    redir_t          exp_q[$];
    logic [ADDR-1:0] exp_pc = RESET_PC_DEF;
    int              xfer_cnt = 0;
    logic [ADDR-1:0] last_pc = '0;

    // Compare each transfer with the reference pc, then apply redirects.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && v_o && !stall_i) begin
                xfer_cnt++;
                last_pc = pc_o;
                checks++;
                if (pc_o !== exp_pc || inst_o !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL xfer: got pc=%h inst=%h expected pc=%h inst=%h",
                             pc_o, inst_o, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 1'b1;
            end
            while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                exp_pc = exp_q[0].tgt;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_redir(input logic fl, input logic br,
                               input logic [ADDR-1:0] fa,
                               input logic [ADDR-1:0] ba);
        flush_i  = fl;
        branch_i = br;
        faddr_i  = fa;
        baddr_i  = ba;
        if (fl || br) exp_q.push_back('{cyc, fl ? fa : ba});
    endtask

    task automatic wait_xfer(input int n, input string nm);
        int k = 0;
        while (xfer_cnt < n && k < 60) begin
            step();
            k++;
        end
        if (xfer_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL %s: no transfer within 60 cycles", nm);
        end
    endtask

    task automatic wait_req(input string nm, input logic [ADDR-1:0] ea);
        int   k = 0;
        logic seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (bus.imem_req_o === 1'b1) seen = 1'b1;
            else k++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no request within 40 cycles", nm);
        end else begin
            chk(nm, 64'(bus.imem_addr_o), 64'(ea));
        end
    endtask

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int k;
        int g0;
        int base;
        int r;
        logic [ADDR-1:0] t1;
        logic [ADDR-1:0] t2;

        // T1: reset held, then release with v_i=1
        v_i = 1'b1;
        bad = 0;
        repeat (128) begin
            @(negedge clk);
            if (bus.imem_req_o !== 1'b0 || v_o !== 1'b0 ||
                pc_o !== '0 || inst_o !== '0) bad++;
        end
        chk("reset_outputs", 64'(bad), 64'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("req_release_cycle", 64'(bus.imem_req_o), 64'(0));
        step();
        @(negedge clk);
        chk("first_req", 64'(bus.imem_req_o), 64'(1));
        chk("first_addr", 64'(bus.imem_addr_o), 64'(0));

        // T3: stall with pc 3 at the head
        step();
        k = 0;
        while (!(v_o === 1'b1 && pc_o === 32'd3) && k < 50) begin
            step();
            k++;
        end
        chk("reach_pc3", 64'(v_o === 1'b1 && pc_o === 32'd3), 64'(1));
        stall_i = 1'b1;
        g0 = gnt_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", {v_o, pc_o, inst_o},
                {1'b1, 32'd3, memf(32'd3)});
            step();
        end
        chk("stall_reads_le2", 64'((gnt_cnt - g0) <= 2), 64'(1));
        stall_i = 1'b0;
        base = xfer_cnt;
        wait_xfer(base + 1, "stall_release");
        chk("release_pc3", 64'(last_pc), 64'(3));
        wait_xfer(base + 2, "after_release");
        chk("release_pc4", 64'(last_pc), 64'(4));

        // T2: steady stream, gnt=1, 1-cycle rvalid
        base = xfer_cnt;
        repeat (30) step();
        chk("stream_rate", 64'((xfer_cnt - base) >= 15), 64'(1));

        // T4: branch with two reads in flight
        dly_min = 3;
        dly_max = 3;
        k = 0;
        while (out_tb != 2 && k < 40) begin
            step();
            k++;
        end
        chk("two_outstanding", 64'(out_tb), 64'(2));
        drive_redir(1'b0, 1'b1, '0, 32'h2);
        @(negedge clk);
        chk("redir_req_low", 64'(bus.imem_req_o), 64'(0));
        step();
        drive_redir(1'b0, 1'b0, '0, '0);
        dly_min = 0;
        dly_max = 0;
        base = xfer_cnt;
        wait_req("branch_req_addr", 32'h2);
        wait_xfer(base + 1, "branch_xfer");
        chk("branch_first_pc", 64'(last_pc), 64'(2));

        // T5: flush and branch together, flush wins
        repeat (3) step();
        drive_redir(1'b1, 1'b1, 32'h40, 32'h2);
        @(negedge clk);
        chk("flush_req_low", 64'(bus.imem_req_o), 64'(0));
        step();
        drive_redir(1'b0, 1'b0, '0, '0);
        base = xfer_cnt;
        wait_req("flush_req_addr", 32'h40);
        wait_xfer(base + 1, "flush_xfer");
        chk("flush_first_pc", 64'(last_pc), 64'(32'h40));

        // Redirect while stalled: stalled word discarded
        stall_i = 1'b1;
        k = 0;
        while (v_o !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk("stall_word_present", 64'(v_o), 64'(1));
        drive_redir(1'b0, 1'b1, '0, 32'h100);
        step();
        drive_redir(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("v_o_cleared", 64'(v_o), 64'(0));
        step();
        stall_i = 1'b0;
        base = xfer_cnt;
        wait_xfer(base + 1, "stall_redir_xfer");
        chk("stall_redir_pc", 64'(last_pc), 64'(32'h100));

        // T6: random gnt/rvalid delays, stalls and redirects
        gnt_pct = 70;
        dly_min = 0;
        dly_max = 3;
        base = xfer_cnt;
        for (int i = 0; i < 10000; i++) begin
            v_i = ($urandom_range(99) < 95);
            stall_i = ($urandom_range(99) < 30);
            r = int'($urandom_range(99));
            t1 = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : ADDR'($urandom);
            t2 = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : ADDR'($urandom);
            drive_redir(r < 2, r >= 1 && r < 4, t1, t2);
            step();
        end
        drive_redir(1'b0, 1'b0, '0, '0);
        v_i = 1'b1;
        stall_i = 1'b0;
        gnt_pct = 100;
        dly_max = 0;
        repeat (40) step();
        chk("random_progress", 64'((xfer_cnt - base) > 1000), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
